i2s_adc_source: RTL and testbench

Codec-side I2S transmitter: the far end of the audio core's ADC input. Acts as bit-clock and frame-clock master and serializes 16-bit left/right sample pairs onto `AUD_ADCDAT`, driving `AUD_BCLK` and `AUD_ADCLRCK`/`AUD_DACLRCK` exactly as the board codec does. Used as the on-chip stand-in for the codec in loopback builds and as the stimulus source for audio-path tests. Samples arrive through a one-entry valid/ready buffer.

---
 rtl/i2s_adc_source_if.sv | 40 ++++
 rtl/i2s_adc_source.sv | 171 +++++++++++++++++
 tb/tb_i2s_adc_source.sv | 381 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_adc_source_if.sv
// ---------------------------------------------------------------------------
// i2s_adc_source_if
//
// Purpose:
//   Sample-pair handshake between a sample producer and the I2S ADC source.
//   One left/right pair moves per cycle in which sample_valid and
//   sample_ready are both high.
//
// Signals:
//   sample_left   [SAMPLE_WIDTH]  left channel sample, two's complement
//   sample_right  [SAMPLE_WIDTH]  right channel sample, two's complement
//   sample_valid                  producer offers a pair
//   sample_ready                  consumer buffer is empty
//
// Modports:
//   master - sample producer (drives data/valid, observes ready)
//   slave  - I2S source (observes data/valid, drives ready)
// ---------------------------------------------------------------------------
interface i2s_adc_source_if #(
    parameter int SAMPLE_WIDTH = 16
);
    logic [SAMPLE_WIDTH-1:0] sample_left;
    logic [SAMPLE_WIDTH-1:0] sample_right;
    logic                    sample_valid;
    logic                    sample_ready;

    modport master (
        output sample_left,
        output sample_right,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_left,
        input  sample_right,
        input  sample_valid,
        output sample_ready
    );
endinterface

// File: rtl/i2s_adc_source.sv
// ---------------------------------------------------------------------------
// i2s_adc_source
//
// Purpose:
//   Codec-side I2S transmitter. Generates BCLK and LRCK as clock master and
//   serializes left/right sample pairs onto AUD_ADCDAT, MSB first, with the
//   standard one-BCLK I2S delay after each LRCK edge. Pairs are taken from a
//   one-entry valid/ready buffer and loaded once per frame.
//
// Parameters:
//   CLK_DIV       clk_clk cycles per BCLK half-period (>= 1)
//   SAMPLE_WIDTH  bits per channel sample
//   SLOT_WIDTH    BCLK periods per channel slot (>= SAMPLE_WIDTH+1)
//
// Ports:
//   clk_clk       in   single clock, rising edge
//   reset_reset   in   synchronous active-high reset
//   sample_if     slave modport: sample_left/right, sample_valid, sample_ready
//   underrun_clr  in   clears the sticky underrun flag
//   AUD_BCLK      out  bit clock
//   AUD_ADCLRCK   out  frame clock, 0 = left slot
//   AUD_DACLRCK   out  copy of AUD_ADCLRCK
//   AUD_ADCDAT    out  serial data
//   frame_start   out  one-cycle pulse in the frame-load cycle
//   underrun      out  sticky, set when a frame loads with the buffer empty
//
// Configuration macro:
//   I2S_HOLD_LAST_EN  when defined, an underrun frame repeats the last pair
//                     that loaded successfully; otherwise it sends zeros.
// ---------------------------------------------------------------------------
module i2s_adc_source #(
    parameter int CLK_DIV      = 4,
    parameter int SAMPLE_WIDTH = 16,
    parameter int SLOT_WIDTH   = 32
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset,
    i2s_adc_source_if.slave       sample_if,
    input  logic                  underrun_clr,
    output logic                  AUD_BCLK,
    output logic                  AUD_ADCLRCK,
    output logic                  AUD_DACLRCK,
    output logic                  AUD_ADCDAT,
    output logic                  frame_start,
    output logic                  underrun
);

    localparam int FRAME_BITS = 2 * SLOT_WIDTH;
    localparam int BW         = $clog2(FRAME_BITS);
    localparam int DW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int PW         = 2 * SAMPLE_WIDTH;
    localparam int IW         = $clog2(PW);

    logic [DW-1:0]           r_div;
    logic                    r_bclk;
    logic                    r_lrck;
    logic                    r_adcdat;
    logic                    r_frame_start;
    logic                    r_underrun;
    logic [BW-1:0]           r_bit;
    logic                    r_full;
    logic [SAMPLE_WIDTH-1:0] r_buf_left;
    logic [SAMPLE_WIDTH-1:0] r_buf_right;
    // Holds {left,right} of the frame being transmitted; bits are picked by
    // index rather than shifted so the contents survive for hold-last.
    logic [PW-1:0]           r_pair;

    logic                    w_tc;
    logic                    w_fall;
    logic [BW-1:0]           w_bit_next;
    logic                    w_load;
    logic                    w_xfer;
    logic                    w_data_bit;
    logic [IW-1:0]           w_sel;

    assign w_tc       = (r_div == DW'(CLK_DIV - 1));
    // All serial-side updates happen on the BCLK high-to-low toggle.
    assign w_fall     = w_tc && r_bclk;
    assign w_bit_next = (r_bit == BW'(FRAME_BITS - 1)) ? '0 : r_bit + 1'b1;
    assign w_load     = w_fall && (w_bit_next == '0);
    assign w_xfer     = sample_if.sample_valid && !r_full;

    // Data bit for the bit position being entered. Left occupies positions
    // 1..SAMPLE_WIDTH and right SLOT_WIDTH+1..SLOT_WIDTH+SAMPLE_WIDTH, one
    // position after each LRCK edge; everything else idles low.
    always_comb begin
        int idx;
        idx        = int'(w_bit_next);
        w_sel      = '0;
        w_data_bit = 1'b0;
        if (idx >= 1 && idx <= SAMPLE_WIDTH) begin
            w_sel      = IW'(PW - idx);
            w_data_bit = r_pair[w_sel];
        end else if (idx >= SLOT_WIDTH + 1 && idx <= SLOT_WIDTH + SAMPLE_WIDTH) begin
            w_sel      = IW'(SLOT_WIDTH + SAMPLE_WIDTH - idx);
            w_data_bit = r_pair[w_sel];
        end
    end

    // Clock divider, serializer, frame load, sample buffer and underrun flag.
    // Reset parks the bit counter on the last position so the first fall
    // after release wraps to zero and performs the first frame load.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_div         <= '0;
            r_bclk        <= 1'b0;
            r_lrck        <= 1'b1;
            r_adcdat      <= 1'b0;
            r_frame_start <= 1'b0;
            r_underrun    <= 1'b0;
            r_bit         <= BW'(FRAME_BITS - 1);
            r_full        <= 1'b0;
            r_buf_left    <= '0;
            r_buf_right   <= '0;
            r_pair        <= '0;
        end else begin
            if (w_tc) begin
                r_div  <= '0;
                r_bclk <= ~r_bclk;
            end else begin
                r_div  <= r_div + 1'b1;
            end

            r_frame_start <= w_load;

            if (w_fall) begin
                r_bit    <= w_bit_next;
                r_lrck   <= (w_bit_next >= BW'(SLOT_WIDTH));
                r_adcdat <= w_data_bit;
            end

            // Frame load looks at the buffer as it stood before this edge, so
            // a pair accepted in the load cycle waits for the next frame.
            if (w_load) begin
                if (r_full) begin
                    r_pair <= {r_buf_left, r_buf_right};
                    r_full <= 1'b0;
                end else begin
`ifdef I2S_HOLD_LAST_EN
                    r_pair <= r_pair;
`else
                    r_pair <= '0;
`endif
                end
            end

            // Accept only when empty; never coincides with the consume above.
            if (w_xfer) begin
                r_buf_left  <= sample_if.sample_left;
                r_buf_right <= sample_if.sample_right;
                r_full      <= 1'b1;
            end

            // A new underrun takes priority over a simultaneous clear.
            if (w_load && !r_full) begin
                r_underrun <= 1'b1;
            end else if (underrun_clr) begin
                r_underrun <= 1'b0;
            end
        end
    end

    assign sample_if.sample_ready = !r_full;
    assign AUD_BCLK               = r_bclk;
    assign AUD_ADCLRCK            = r_lrck;
    assign AUD_DACLRCK            = r_lrck;
    assign AUD_ADCDAT             = r_adcdat;
    assign frame_start            = r_frame_start;
    assign underrun               = r_underrun;

endmodule

// File: tb/tb_i2s_adc_source.sv
// ---------------------------------------------------------------------------
// tb_i2s_adc_source
//
// Purpose:
//   Directed testbench for i2s_adc_source at default parameters
//   (CLK_DIV=4, SAMPLE_WIDTH=16, SLOT_WIDTH=32: 8 clk per bit, 512 per frame).
//   Inputs change on the falling edge of clk, outputs are sampled there too.
//   Honours I2S_HOLD_LAST_EN for underrun-frame expectations.
// ---------------------------------------------------------------------------
module tb_i2s_adc_source;

    localparam int CLK_DIV      = 4;
    localparam int SAMPLE_WIDTH = 16;
    localparam int SLOT_WIDTH   = 32;
    localparam int BIT_CLKS     = 2 * CLK_DIV;
    localparam int FRAME_CLKS   = 2 * SLOT_WIDTH * BIT_CLKS;

    localparam logic [63:0] DATA_MASK = 64'h0001FFFE_0001FFFE;
    localparam logic [63:0] LRCK_EXP  = 64'hFFFFFFFF_00000000;

    logic clk;
    logic reset;
    logic underrun_clr;
    logic aud_bclk;
    logic aud_adclrck;
    logic aud_daclrck;
    logic aud_adcdat;
    logic frame_start;
    logic underrun;

    int checks;
    int errors;

    i2s_adc_source_if #(.SAMPLE_WIDTH(SAMPLE_WIDTH)) sif ();

    i2s_adc_source #(
        .CLK_DIV      (CLK_DIV),
        .SAMPLE_WIDTH (SAMPLE_WIDTH),
        .SLOT_WIDTH   (SLOT_WIDTH)
    ) dut (
        .clk_clk      (clk),
        .reset_reset  (reset),
        .sample_if    (sif),
        .underrun_clr (underrun_clr),
        .AUD_BCLK     (aud_bclk),
        .AUD_ADCLRCK  (aud_adclrck),
        .AUD_DACLRCK  (aud_daclrck),
        .AUD_ADCDAT   (aud_adcdat),
        .frame_start  (frame_start),
        .underrun     (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected ADCDAT pattern indexed by bit position for a given pair.
    function automatic logic [63:0] expFrame(input logic [15:0] l, input logic [15:0] r);
        logic [63:0] f;
        f = '0;
        for (int i = 0; i < 16; i++) begin
            f[1 + i]  = l[15 - i];
            f[33 + i] = r[15 - i];
        end
        return f;
    endfunction

    // Records one frame starting at the bit-0 sample point; returns at the
    // next frame's bit-0 sample point.
    task automatic capture_frame(output logic [63:0] adc, output logic [63:0] lr);
        for (int b = 0; b < 64; b++) begin
            adc[b] = aud_adcdat;
            lr[b]  = aud_adclrck;
            repeat (BIT_CLKS) @(negedge clk);
        end
    endtask

    // Reset values and first BCLK rise/fall timing after release.
    task automatic test_reset();
        reset             = 1'b1;
        underrun_clr      = 1'b0;
        sif.sample_valid  = 1'b0;
        sif.sample_left   = '0;
        sif.sample_right  = '0;
        repeat (5) @(negedge clk);
        checks++;
        if ({aud_bclk, aud_adclrck, aud_daclrck, aud_adcdat, sif.sample_ready, frame_start, underrun} !== 7'b0110100) begin
            errors++;
            $display("[TB] FAIL reset_values got %b expected 0110100", {aud_bclk, aud_adclrck, aud_daclrck, aud_adcdat, sif.sample_ready, frame_start, underrun});
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (aud_bclk !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bclk_edge3 got %b expected 0", aud_bclk);
        end
        @(negedge clk);
        checks++;
        if (aud_bclk !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bclk_rise_edge4 got %b expected 1", aud_bclk);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (aud_bclk !== 1'b1 || aud_adclrck !== 1'b1) begin
            errors++;
            $display("[TB] FAIL before_first_fall got bclk=%b lrck=%b expected 1 1", aud_bclk, aud_adclrck);
        end
        @(negedge clk);
        checks++;
        if ({aud_bclk, aud_adclrck, aud_daclrck, frame_start, underrun, sif.sample_ready} !== 6'b000111) begin
            errors++;
            $display("[TB] FAIL first_fall got %b expected 000111", {aud_bclk, aud_adclrck, aud_daclrck, frame_start, underrun, sif.sample_ready});
        end
        @(negedge clk);
        checks++;
        if (frame_start !== 1'b0) begin
            errors++;
            $display("[TB] FAIL frame_start_pulse_width got %b expected 0", frame_start);
        end
    endtask

    // One pair offered in frame 1, serialized in frame 2.
    task automatic test_data();
        logic [63:0] adc;
        logic [63:0] lr;
        logic [15:0] lgot;
        logic [15:0] rgot;
        bit          found;
        checks++;
        if (sif.sample_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL data_ready_before got %b expected 1", sif.sample_ready);
        end
        sif.sample_valid = 1'b1;
        sif.sample_left  = 16'hA5C3;
        sif.sample_right = 16'h1234;
        @(negedge clk);
        sif.sample_valid = 1'b0;
        checks++;
        if (sif.sample_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL data_ready_after_accept got %b expected 0", sif.sample_ready);
        end
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME_CLKS && !found; i++) begin
            @(negedge clk);
            if (frame_start === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("[TB] FAIL data_frame_start_timeout got none expected pulse within %0d clk", 2 * FRAME_CLKS);
        end
        checks++;
        if (sif.sample_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL data_ready_after_load got %b expected 1", sif.sample_ready);
        end
        capture_frame(adc, lr);
        for (int i = 0; i < 16; i++) begin
            lgot[15 - i] = adc[1 + i];
            rgot[15 - i] = adc[33 + i];
        end
        checks++;
        if (lgot !== 16'hA5C3) begin
            errors++;
            $display("[TB] FAIL data_left got %h expected a5c3", lgot);
        end
        checks++;
        if (rgot !== 16'h1234) begin
            errors++;
            $display("[TB] FAIL data_right got %h expected 1234", rgot);
        end
        checks++;
        if ((adc & ~DATA_MASK) !== 64'h0) begin
            errors++;
            $display("[TB] FAIL data_idle_bits got %h expected 0", adc & ~DATA_MASK);
        end
        checks++;
        if (lr !== LRCK_EXP) begin
            errors++;
            $display("[TB] FAIL data_lrck got %h expected %h", lr, LRCK_EXP);
        end
    endtask

    // Valid held high with incrementing data over three frames.
    task automatic test_back_to_back();
        logic [63:0] adc;
        logic [63:0] lr;
        int          k;
        int          xfers;
        int          starts;
        bit          took;
        k                = 1;
        xfers            = 0;
        starts           = 0;
        underrun_clr     = 1'b1;
        sif.sample_valid = 1'b1;
        sif.sample_left  = 16'h1001;
        sif.sample_right = 16'h2001;
        for (int i = 0; i < 3 * FRAME_CLKS; i++) begin
            if (frame_start === 1'b1) starts++;
            took = (sif.sample_ready === 1'b1);
            if (took) xfers++;
            @(negedge clk);
            underrun_clr = 1'b0;
            if (took) begin
                k++;
                sif.sample_left  = 16'h1000 + 16'(k);
                sif.sample_right = 16'h2000 + 16'(k);
            end
        end
        sif.sample_valid = 1'b0;
        checks++;
        if (xfers !== 3) begin
            errors++;
            $display("[TB] FAIL b2b_transfers got %0d expected 3", xfers);
        end
        checks++;
        if (starts !== 3) begin
            errors++;
            $display("[TB] FAIL b2b_frame_starts got %0d expected 3", starts);
        end
        checks++;
        if (underrun !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_no_underrun got %b expected 0", underrun);
        end
        capture_frame(adc, lr);
        checks++;
        if (adc !== expFrame(16'h1003, 16'h2003)) begin
            errors++;
            $display("[TB] FAIL b2b_third_pair got %h expected %h", adc, expFrame(16'h1003, 16'h2003));
        end
    endtask

    // Underrun frame content, clear, and clear colliding with a new underrun.
    task automatic test_underrun();
        logic [63:0] adc;
        logic [63:0] lr;
        logic [63:0] expAdc;
`ifdef I2S_HOLD_LAST_EN
        expAdc = expFrame(16'h1003, 16'h2003);
`else
        expAdc = 64'h0;
`endif
        checks++;
        if (frame_start !== 1'b1 || underrun !== 1'b1) begin
            errors++;
            $display("[TB] FAIL underrun_set got fs=%b ur=%b expected 1 1", frame_start, underrun);
        end
        capture_frame(adc, lr);
        checks++;
        if (adc !== expAdc) begin
            errors++;
            $display("[TB] FAIL underrun_frame_data got %h expected %h", adc, expAdc);
        end
        underrun_clr = 1'b1;
        @(negedge clk);
        underrun_clr = 1'b0;
        checks++;
        if (underrun !== 1'b0) begin
            errors++;
            $display("[TB] FAIL underrun_clear got %b expected 0", underrun);
        end
        repeat (FRAME_CLKS - 2) @(negedge clk);
        underrun_clr = 1'b1;
        @(negedge clk);
        underrun_clr = 1'b0;
        checks++;
        if (frame_start !== 1'b1 || underrun !== 1'b1) begin
            errors++;
            $display("[TB] FAIL underrun_set_beats_clear got fs=%b ur=%b expected 1 1", frame_start, underrun);
        end
    endtask

    // Pair first offered in the frame-load cycle: that frame underruns.
    task automatic test_valid_on_load();
        logic [63:0] adc;
        logic [63:0] lr;
        logic [63:0] expAdc;
`ifdef I2S_HOLD_LAST_EN
        expAdc = expFrame(16'h1003, 16'h2003);
`else
        expAdc = 64'h0;
`endif
        underrun_clr = 1'b1;
        @(negedge clk);
        underrun_clr = 1'b0;
        checks++;
        if (underrun !== 1'b0) begin
            errors++;
            $display("[TB] FAIL vol_clear got %b expected 0", underrun);
        end
        repeat (FRAME_CLKS - 2) @(negedge clk);
        checks++;
        if (sif.sample_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL vol_ready got %b expected 1", sif.sample_ready);
        end
        sif.sample_valid = 1'b1;
        sif.sample_left  = 16'h8001;
        sif.sample_right = 16'h7FFE;
        @(negedge clk);
        sif.sample_valid = 1'b0;
        checks++;
        if ({frame_start, underrun, sif.sample_ready} !== 3'b110) begin
            errors++;
            $display("[TB] FAIL vol_load got fs/ur/rdy=%b expected 110", {frame_start, underrun, sif.sample_ready});
        end
        capture_frame(adc, lr);
        checks++;
        if (adc !== expAdc) begin
            errors++;
            $display("[TB] FAIL vol_underrun_frame got %h expected %h", adc, expAdc);
        end
        checks++;
        if (sif.sample_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL vol_ready_after_load got %b expected 1", sif.sample_ready);
        end
        capture_frame(adc, lr);
        checks++;
        if (adc !== expFrame(16'h8001, 16'h7FFE)) begin
            errors++;
            $display("[TB] FAIL vol_next_frame got %h expected %h", adc, expFrame(16'h8001, 16'h7FFE));
        end
    endtask

    // Reset at bit 20 with the buffer full.
    task automatic test_reset_mid();
        logic [63:0] adc;
        logic [63:0] lr;
        sif.sample_valid = 1'b1;
        sif.sample_left  = 16'hFFFF;
        sif.sample_right = 16'hFFFF;
        @(negedge clk);
        sif.sample_valid = 1'b0;
        checks++;
        if (sif.sample_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_buffer_full got %b expected 0", sif.sample_ready);
        end
        repeat (20 * BIT_CLKS - 1) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({aud_bclk, aud_adclrck, aud_daclrck, aud_adcdat, sif.sample_ready, frame_start, underrun} !== 7'b0110100) begin
            errors++;
            $display("[TB] FAIL mid_reset_values got %b expected 0110100", {aud_bclk, aud_adclrck, aud_daclrck, aud_adcdat, sif.sample_ready, frame_start, underrun});
        end
        repeat (BIT_CLKS) @(negedge clk);
        checks++;
        if ({frame_start, underrun, aud_adclrck} !== 3'b110) begin
            errors++;
            $display("[TB] FAIL mid_first_load got fs/ur/lrck=%b expected 110", {frame_start, underrun, aud_adclrck});
        end
        capture_frame(adc, lr);
        checks++;
        if (adc !== 64'h0) begin
            errors++;
            $display("[TB] FAIL mid_post_reset_frame got %h expected 0", adc);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_data();
        test_back_to_back();
        test_underrun();
        test_valid_on_load();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
